line_fill: RTL

//  Burst-read master sitting between the instruction cache and the bmain bus.

---
 rtl/bmain_pkg.sv | 13 +
 rtl/line_fill_if.sv | 25 ++
 rtl/line_fill.sv | 113 +++++++++++
 3 files changed

// File: rtl/bmain_pkg.sv
// Shared bmain bus types and the line-fill engine state encoding.
package bmain_pkg;
  typedef enum logic {BMAIN_READ = 1'b0, BMAIN_WRITE = 1'b1} bmain_cmd_e;

  localparam int BMAIN_ADDR_W = 26;

  typedef enum logic [1:0] {
    LF_IDLE = 2'd0,
    LF_CMD  = 2'd1,
    LF_DATA = 2'd2,
    LF_DONE = 2'd3
  } line_fill_state_e;
endpackage

// File: rtl/line_fill_if.sv
// bmain command / read-response / error channel as seen by a bus master.
interface line_fill_if;
  import bmain_pkg::*;

  logic                    lf_cvalid;
  logic                    bmain_cready;
  bmain_cmd_e              lf_cmd;
  logic [BMAIN_ADDR_W-1:0] lf_addr;
  logic                    bmain_rvalid;
  logic                    lf_rready;
  logic                    bmain_rlast;
  logic [31:0]             bmain_rdata;
  logic                    bmain_error;
  logic                    lf_eack;

  modport master (
    output lf_cvalid, lf_cmd, lf_addr, lf_rready, lf_eack,
    input  bmain_cready, bmain_rvalid, bmain_rlast, bmain_rdata, bmain_error
  );

  modport slave (
    input  lf_cvalid, lf_cmd, lf_addr, lf_rready, lf_eack,
    output bmain_cready, bmain_rvalid, bmain_rlast, bmain_rdata, bmain_error
  );
endinterface

// File: rtl/line_fill.sv
// I-cache line fill engine: one burst read per miss, line returned via
// valid/ready with an error flag for bus errors and malformed bursts.
module line_fill
  import bmain_pkg::*;
#(
  parameter int BEATS    = 4,
  parameter int LINE_LSB = 4
) (
  input  logic                   clk_core,
  input  logic                   reset,
  input  logic                   miss_valid,
  output logic                   miss_ready,
  input  logic [27-LINE_LSB:0]   miss_addr,
  output logic                   fill_valid,
  input  logic                   fill_ready,
  output logic [27-LINE_LSB:0]   fill_line_addr,
  output logic [32*BEATS-1:0]    fill_data,
  output logic                   fill_error,
  line_fill_if.master            bm
);

  localparam int CNT_W = $clog2(BEATS);

  line_fill_state_e state, state_nxt;

  logic [27-LINE_LSB:0]     addr_q;
  logic [BEATS-1:0][31:0]   line_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     err_q;
  logic                     drop_q;
  logic                     eack_q;

  logic beat, last_slot, bus_err;

  assign beat      = bm.bmain_rvalid & bm.lf_rready;
  assign last_slot = (cnt_q == CNT_W'(BEATS-1));
  assign bus_err   = bm.bmain_error & ((state == LF_CMD) | (state == LF_DATA));

  assign miss_ready     = (state == LF_IDLE);
  assign fill_valid     = (state == LF_DONE);
  assign fill_error     = (state == LF_DONE) & err_q;
  assign fill_line_addr = addr_q;
  assign fill_data      = line_q;

  assign bm.lf_cvalid = (state == LF_CMD);
  assign bm.lf_rready = (state == LF_DATA);
  assign bm.lf_cmd    = BMAIN_READ;
  assign bm.lf_addr   = {addr_q, (LINE_LSB-2)'(0)};
  assign bm.lf_eack   = eack_q;

  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) state <= LF_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LF_IDLE: if (miss_valid) state_nxt = LF_CMD;
      LF_CMD: begin
        if (bus_err)                state_nxt = LF_DONE;
        else if (bm.bmain_cready)   state_nxt = LF_DATA;
      end
      LF_DATA: begin
        if (bus_err)                      state_nxt = LF_DONE;
        else if (beat && bm.bmain_rlast)  state_nxt = LF_DONE;
      end
      LF_DONE: if (fill_ready) state_nxt = LF_IDLE;
      default: state_nxt = LF_IDLE;
    endcase
  end

  // Ack any slave error as a single-cycle pulse regardless of state.
  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      err_q  <= 1'b0;
      drop_q <= 1'b0;
      eack_q <= 1'b0;
    end else begin
      eack_q <= bm.bmain_error & ~eack_q;
      case (state)
        LF_IDLE: if (miss_valid) begin
          err_q  <= 1'b0;
          drop_q <= 1'b0;
        end
        LF_CMD: begin
          if (bm.bmain_cready) cnt_q <= '0;
          if (bus_err)         err_q <= 1'b1;
        end
        LF_DATA: begin
          if (beat && !drop_q) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (bm.bmain_rlast && !last_slot) err_q <= 1'b1;
            // Overlong burst: flag it and swallow beats until rlast.
            if (!bm.bmain_rlast && last_slot) begin
              err_q  <= 1'b1;
              drop_q <= 1'b1;
            end
          end
          if (bus_err) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_core) begin
    if (state == LF_IDLE && miss_valid) addr_q <= miss_addr;
    if (state == LF_DATA && beat && !drop_q) line_q[cnt_q] <= bm.bmain_rdata;
  end

endmodule
